// File: rtl/mips_run_ctrl.sv
// Run controller for a MIPS core: holds the core in reset, runs it, then stops on
// halt, a self-loop on the PC, or a cycle budget, and reports the cause.
module mips_run_ctrl #(
  parameter int unsigned RST_CYCLES  = 5,
  parameter int unsigned MAX_CYCLES  = 500,
  parameter int unsigned LOOP_CYCLES = 4,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  input  logic [PC_W-1:0]  pc,
  output logic             core_reset,
  output logic             running,
  output logic             done,
  output logic             halted,
  output logic             loop_hit,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned HoldW = $clog2(RST_CYCLES + 1);
  localparam int unsigned LoopW = $clog2(LOOP_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RST_CYCLES - 1);
  localparam logic [LoopW-1:0] LoopLast = LoopW'(LOOP_CYCLES - 1);
  localparam logic [CNT_W-1:0] MaxLast  = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {StHold, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [LoopW-1:0]  loop_cnt_q, loop_cnt_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
  logic [PC_W-1:0]   pc_prev_q, pc_prev_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic              loop_hit_q, loop_hit_d;
  logic              timeout_q, timeout_d;
  logic              pc_match, loop_cond, timeout_cond;

  // The first RUN edge after entry only captures the PC, so valid gates matching.
  assign pc_match     = valid_q && (pc == pc_prev_q);
  assign loop_cond    = pc_match && (loop_cnt_q == LoopLast);
  assign timeout_cond = (cycle_count_q == MaxLast);

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    loop_cnt_d    = loop_cnt_q;
    cycle_count_d = cycle_count_q;
    pc_prev_d     = pc_prev_q;
    valid_d       = valid_q;
    halted_d      = halted_q;
    loop_hit_d    = loop_hit_q;
    timeout_d     = timeout_q;
    unique case (state_q)
      StHold: begin
        if (hold_cnt_q == HoldLast) begin
          state_d       = StRun;
          hold_cnt_d    = '0;
          cycle_count_d = '0;
          loop_cnt_d    = '0;
          valid_d       = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      StRun: begin
        cycle_count_d = cycle_count_q + 1'b1;
        pc_prev_d     = pc;
        valid_d       = 1'b1;
        loop_cnt_d    = pc_match ? loop_cnt_q + 1'b1 : '0;
        if (halt) begin
          halted_d = 1'b1;
          state_d  = StDone;
        end else if (loop_cond) begin
          loop_hit_d = 1'b1;
          state_d    = StDone;
        end else if (timeout_cond) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end
      end
      StDone: begin
        if (start) begin
          halted_d   = 1'b0;
          loop_hit_d = 1'b0;
          timeout_d  = 1'b0;
          hold_cnt_d = '0;
          state_d    = StHold;
        end
      end
      default: state_d = StHold;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StHold;
      hold_cnt_q    <= '0;
      loop_cnt_q    <= '0;
      cycle_count_q <= '0;
      pc_prev_q     <= '0;
      valid_q       <= 1'b0;
      halted_q      <= 1'b0;
      loop_hit_q    <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      loop_cnt_q    <= loop_cnt_d;
      cycle_count_q <= cycle_count_d;
      pc_prev_q     <= pc_prev_d;
      valid_q       <= valid_d;
      halted_q      <= halted_d;
      loop_hit_q    <= loop_hit_d;
      timeout_q     <= timeout_d;
    end
  end

  assign core_reset  = (state_q == StHold);
  assign running     = (state_q == StRun);
  assign done        = (state_q == StDone);
  assign halted      = halted_q;
  assign loop_hit    = loop_hit_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: a phase/history model checked every cycle, plus
// hand-computed checkpoints for the directed scenarios.
module tb_mips_run_ctrl;

  localparam int RstC  = 5;
  localparam int MaxC  = 500;
  localparam int LoopC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        halt;
  logic [31:0] pc;
  logic        core_reset, running, done, halted, loop_hit, timeout;
  logic [15:0] cycle_count;

  int errors = 0;
  int checks = 0;

  mips_run_ctrl #(
    .RST_CYCLES (RstC),
    .MAX_CYCLES (MaxC),
    .LOOP_CYCLES(LoopC),
    .PC_W       (32),
    .CNT_W      (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .halt       (halt),
    .pc         (pc),
    .core_reset (core_reset),
    .running    (running),
    .done       (done),
    .halted     (halted),
    .loop_hit   (loop_hit),
    .timeout    (timeout),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Model: phase 0=hold, 1=run, 2=done; run length and recent PC samples.
  int          m_phase = 0;
  int          m_hold  = 0;
  int          m_runs  = 0;
  logic        m_halted = 1'b0, m_loop = 1'b0, m_to = 1'b0;
  logic [31:0] m_hist[$];

  function automatic logic self_loop();
    if (m_hist.size() != LoopC + 1) return 1'b0;
    foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_hold = 0; m_runs = 0;
      m_halted = 0; m_loop = 0; m_to = 0;
      m_hist.delete();
    end else begin
      case (m_phase)
        0: begin
          m_hold++;
          if (m_hold == RstC) begin
            m_phase = 1; m_hold = 0; m_runs = 0; m_hist.delete();
          end
        end
        1: begin
          m_runs++;
          m_hist.push_back(pc);
          if (m_hist.size() > LoopC + 1) void'(m_hist.pop_front());
          if (halt) m_halted = 1;
          else if (self_loop()) m_loop = 1;
          else if (m_runs == MaxC) m_to = 1;
          if (m_halted || m_loop || m_to) m_phase = 2;
        end
        default: begin
          if (start) begin
            m_halted = 0; m_loop = 0; m_to = 0; m_phase = 0; m_hold = 0;
          end
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("core_reset", 32'(core_reset), 32'(m_phase == 0));
    chk("running", 32'(running), 32'(m_phase == 1));
    chk("done", 32'(done), 32'(m_phase == 2));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("loop_hit", 32'(loop_hit), 32'(m_loop));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("cycle_count", 32'(cycle_count), 32'(m_runs));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic restart();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_core_reset", 32'(core_reset), 32'd1);
    chk("restart_flags", {29'd0, halted, loop_hit, timeout}, 32'd0);
    for (int i = 1; i < RstC; i++) step();
    chk("restart_still_hold", 32'(core_reset), 32'd1);
    step();
    chk("restart_running", 32'(running), 32'd1);
    chk("restart_count0", 32'(cycle_count), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt = 1'b0; pc = 32'h0;
    #2 reset = 1'b0;
    #1;
    compare();
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_count", 32'(cycle_count), 32'd0);
    @(negedge clk) reset = 1'b1;

    // Timeout run with pc stepping by 4.
    for (int i = 1; i <= RstC; i++) begin
      pc = pc + 32'd4;
      step();
      if (i == RstC - 1) chk("hold_edge4_core_reset", 32'(core_reset), 32'd1);
    end
    chk("run_after_5", 32'(running), 32'd1);
    for (int k = 1; k <= MaxC; k++) begin
      pc = pc + 32'd4;
      step();
    end
    chk("to_done", 32'(done), 32'd1);
    chk("to_flag", 32'(timeout), 32'd1);
    chk("to_count", 32'(cycle_count), 32'd500);
    for (int i = 0; i < 3; i++) begin
      pc = pc + 32'd4; halt = 1'b1;
      step();
    end
    halt = 1'b0;
    chk("done_hold_count", 32'(cycle_count), 32'd500);

    // Halt on RUN edge 37.
    restart();
    for (int k = 1; k <= 37; k++) begin
      pc = pc + 32'd4;
      halt = (k == 37);
      step();
    end
    halt = 1'b0;
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_count", 32'(cycle_count), 32'd37);
    for (int i = 0; i < 3; i++) begin
      pc = pc + 32'd4;
      step();
    end
    chk("halt_count_held", 32'(cycle_count), 32'd37);

    // Self-loop at 0x40 from RUN edge 10.
    restart();
    for (int k = 1; k <= 14; k++) begin
      pc = (k >= 10) ? 32'h40 : 32'h1000 + 32'(4 * k);
      step();
      if (k == 13) chk("loop_not_yet", 32'(loop_hit), 32'd0);
    end
    chk("loop_flag", 32'(loop_hit), 32'd1);
    chk("loop_count", 32'(cycle_count), 32'd14);

    // Halt beats loop and timeout on RUN edge 500; halt ignored during hold.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < RstC; i++) begin
      halt = 1'b1;
      step();
    end
    halt = 1'b0;
    chk("hold_halt_ignored", 32'(running), 32'd1);
    for (int k = 1; k <= MaxC; k++) begin
      pc = (k >= 496) ? 32'h80 : 32'h2000 + 32'(4 * k);
      halt = (k == MaxC);
      step();
    end
    halt = 1'b0;
    chk("prio_halted", 32'(halted), 32'd1);
    chk("prio_loop", 32'(loop_hit), 32'd0);
    chk("prio_to", 32'(timeout), 32'd0);

    // Asynchronous reset at RUN edge 200; start ignored in RUN.
    restart();
    for (int k = 1; k <= 200; k++) begin
      pc = pc + 32'd4;
      start = (k < 5);
      step();
    end
    start = 1'b0;
    chk("pre_reset_count", 32'(cycle_count), 32'd200);
    #3 reset = 1'b0;
    #1;
    compare();
    chk("async_core_reset", 32'(core_reset), 32'd1);
    chk("async_count", 32'(cycle_count), 32'd0);
    chk("async_flags", {29'd0, halted, loop_hit, timeout}, 32'd0);
    #2 reset = 1'b1;
    for (int i = 0; i < RstC; i++) step();
    chk("post_reset_running", 32'(running), 32'd1);
    for (int i = 0; i < 3; i++) begin
      pc = pc + 32'd4;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
